// File: rtl/sel2_arbiter_if.sv
// Requester/grant/data bundle between two producers and the sel2_arbiter.
// master = requester side, slave = arbiter side.
interface sel2_arbiter_if #(
    parameter int WIDTH = 1
);
    logic             REQ_A;
    logic             REQ_B;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             GNT_A;
    logic             GNT_B;
    logic             SEL;
    logic [WIDTH-1:0] OUT;
    logic             OUT_VALID;

    modport master (
        output REQ_A, REQ_B, A, B,
        input  GNT_A, GNT_B, SEL, OUT, OUT_VALID
    );

    modport slave (
        input  REQ_A, REQ_B, A, B,
        output GNT_A, GNT_B, SEL, OUT, OUT_VALID
    );
endinterface

// File: rtl/sel2_arbiter.sv
// Round-robin two-requester arbiter with bounded hold time; owns the 2:1
// select line and registers the selected word. All outputs are registered.
module sel2_arbiter #(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 4
) (
    input logic           CLK,
    input logic           RST_N,
    sel2_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

    localparam logic [8:0] HOLD_LIM = 9'(MAX_HOLD);
    localparam logic [7:0] CNT_MAX  = 8'(MAX_HOLD);

    state_t           state_q;
    state_t           state_d;
    logic             last_q;     // 1 = B was granted last
    logic [7:0]       cnt_q;
    logic             sel_q;
    logic [WIDTH-1:0] out_p0;
    logic             vld_p0;
    logic             xfer;
    logic             hold_done;

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c >= CNT_MAX) ? CNT_MAX : c + 8'd1;
    endfunction

    always_comb begin
        state_d   = state_q;
        xfer      = 1'b0;
        hold_done = ({1'b0, cnt_q} + 9'd1) >= HOLD_LIM;
        case (state_q)
            IDLE: begin
                if (bus.REQ_A && bus.REQ_B)
                    state_d = last_q ? GRANT_A : GRANT_B;
                else if (bus.REQ_A)
                    state_d = GRANT_A;
                else if (bus.REQ_B)
                    state_d = GRANT_B;
            end
            GRANT_A: begin
                if (!bus.REQ_A) begin
                    state_d = bus.REQ_B ? GRANT_B : IDLE;
                end else begin
                    xfer = 1'b1;
                    if (bus.REQ_B && hold_done)
                        state_d = GRANT_B;
                end
            end
            GRANT_B: begin
                if (!bus.REQ_B) begin
                    state_d = bus.REQ_A ? GRANT_A : IDLE;
                end else begin
                    xfer = 1'b1;
                    if (bus.REQ_A && hold_done)
                        state_d = GRANT_A;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage p0: transfer capture and grant bookkeeping
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
            sel_q   <= 1'b0;
            out_p0  <= '0;
            vld_p0  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                out_p0 <= sel_q ? bus.B : bus.A;
                vld_p0 <= 1'b1;
                cnt_q  <= sat_inc(cnt_q);
            end else begin
                vld_p0 <= 1'b0;
            end
            // Grant entry overrides the count update of a handoff transfer
            if (state_d != state_q) begin
                if (state_d == GRANT_A) begin
                    sel_q  <= 1'b0;
                    last_q <= 1'b0;
                    cnt_q  <= 8'd0;
                end else if (state_d == GRANT_B) begin
                    sel_q  <= 1'b1;
                    last_q <= 1'b1;
                    cnt_q  <= 8'd0;
                end
            end
        end
    end

    assign bus.GNT_A     = (state_q == GRANT_A);
    assign bus.GNT_B     = (state_q == GRANT_B);
    assign bus.SEL       = sel_q;
    assign bus.OUT       = out_p0;
    assign bus.OUT_VALID = vld_p0;
endmodule

// File: tb/tb_sel2_arbiter.sv
// Bench for sel2_arbiter: MAX_HOLD=4 and MAX_HOLD=1 instances, directed
// vectors with a transfer-data scoreboard drained by per-instance monitors.
module tb_sel2_arbiter;
    localparam int W = 4;

    logic CLK = 1'b0;
    logic rst_n0;
    logic rst_n1;

    always #5 CLK = ~CLK;

    sel2_arbiter_if #(.WIDTH(W)) bus0 ();
    sel2_arbiter_if #(.WIDTH(W)) bus1 ();

    sel2_arbiter #(.WIDTH(W), .MAX_HOLD(4)) dut0 (
        .CLK  (CLK),
        .RST_N(rst_n0),
        .bus  (bus0.slave)
    );

    sel2_arbiter #(.WIDTH(W), .MAX_HOLD(1)) dut1 (
        .CLK  (CLK),
        .RST_N(rst_n1),
        .bus  (bus1.slave)
    );

    int         tests = 0;
    int         fails = 0;
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic         prev_x[2];
    logic [W-1:0] e0;
    logic [W-1:0] e1;

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Scoreboard monitors: every OUT_VALID pulse must match the oldest pending transfer
    always @(negedge CLK) begin
        if (bus0.OUT_VALID === 1'b1) begin
            if (q0.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL out0: unexpected transfer got %0h expected none", bus0.OUT);
            end else begin
                e0 = q0.pop_front();
                chk("out0 data", bus0.OUT, e0);
            end
        end
    end

    always @(negedge CLK) begin
        if (bus1.OUT_VALID === 1'b1) begin
            if (q1.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL out1: unexpected transfer got %0h expected none", bus1.OUT);
            end else begin
                e1 = q1.pop_front();
                chk("out1 data", bus1.OUT, e1);
            end
        end
    end

    // One clock cycle: drive inputs, check the hand-computed grant/sel state,
    // and queue the word that a transfer in this cycle must deliver.
    task automatic step(input int d, input logic rn, input logic ra, input logic rb,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ega, input logic egb, input logic esel,
                        input string nm);
        logic x;
        if (d == 0) begin
            rst_n0 = rn; bus0.REQ_A = ra; bus0.REQ_B = rb; bus0.A = a; bus0.B = b;
        end else begin
            rst_n1 = rn; bus1.REQ_A = ra; bus1.REQ_B = rb; bus1.A = a; bus1.B = b;
        end
        @(negedge CLK);
        if (d == 0) begin
            chk({nm, " gnt_a"}, W'(bus0.GNT_A), W'(ega));
            chk({nm, " gnt_b"}, W'(bus0.GNT_B), W'(egb));
            chk({nm, " sel"}, W'(bus0.SEL), W'(esel));
            chk({nm, " out_valid"}, W'(bus0.OUT_VALID), W'(prev_x[0]));
        end else begin
            chk({nm, " gnt_a"}, W'(bus1.GNT_A), W'(ega));
            chk({nm, " gnt_b"}, W'(bus1.GNT_B), W'(egb));
            chk({nm, " sel"}, W'(bus1.SEL), W'(esel));
            chk({nm, " out_valid"}, W'(bus1.OUT_VALID), W'(prev_x[1]));
        end
        x = rn && ((ega && ra) || (egb && rb));
        if (x) begin
            if (d == 0) q0.push_back(ega ? a : b);
            else        q1.push_back(ega ? a : b);
        end
        prev_x[d] = x;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        prev_x[0] = 1'b0;
        prev_x[1] = 1'b0;
        rst_n0 = 1'b0;
        rst_n1 = 1'b0;
        bus0.REQ_A = 1'b0; bus0.REQ_B = 1'b0; bus0.A = '0; bus0.B = '0;
        bus1.REQ_A = 1'b0; bus1.REQ_B = 1'b0; bus1.A = '0; bus1.B = '0;
        @(posedge CLK);
        #1;

        // Reset with both requesting, then contention AAAABBBBAAAA
        step(0, 0, 1, 1, 4'h1, 4'h0, 0, 0, 0, "rst");
        step(0, 0, 1, 1, 4'h1, 4'h0, 0, 0, 0, "rst");
        chk("rst out", bus0.OUT, 4'h0);
        step(0, 1, 1, 1, 4'h1, 4'h0, 0, 0, 0, "release");
        for (int i = 0; i < 12; i++) begin
            logic ga;
            ga = (i < 4) || (i >= 8);
            step(0, 1, 1, 1, W'(i), W'(15 - i), ga, !ga, !ga, "contend");
        end
        step(0, 1, 0, 0, 4'h0, 4'h0, 0, 1, 1, "drop both");

        // Single requester with toggling data, then saturated hold switch
        step(0, 1, 1, 0, 4'h5, 4'h0, 0, 0, 1, "idle sel held");
        for (int i = 0; i < 5; i++)
            step(0, 1, 1, 0, (i % 2 == 1) ? 4'hA : 4'h5, 4'h0, 1, 0, 0, "single");
        step(0, 1, 1, 1, 4'h7, 4'h8, 1, 0, 0, "sat switch");
        step(0, 1, 1, 0, 4'h7, 4'h8, 0, 1, 1, "b drop");

        // Early release by A while B waits
        for (int i = 0; i < 2; i++)
            step(0, 1, 1, 1, W'(2 + i), 4'h9, 1, 0, 0, "early a");
        step(0, 1, 0, 1, 4'h2, 4'h9, 1, 0, 0, "a drop");
        step(0, 1, 0, 1, 4'h2, 4'hB, 0, 1, 1, "b after release");
        step(0, 1, 0, 0, 4'h0, 4'hB, 0, 1, 1, "b drops");
        step(0, 1, 0, 0, 4'h0, 4'h0, 0, 0, 1, "idle");

        // Mid-grant reset in GRANT_B with CNT=2
        step(0, 1, 0, 1, 4'h0, 4'hD, 0, 0, 1, "idle b req");
        step(0, 1, 0, 1, 4'h0, 4'hD, 0, 1, 1, "b x1");
        step(0, 1, 0, 1, 4'h0, 4'hD, 0, 1, 1, "b x2");
        step(0, 0, 1, 1, 4'h6, 4'hD, 0, 1, 1, "mid rst");
        chk("mid rst out", bus0.OUT, 4'h0);
        step(0, 1, 1, 1, 4'h6, 4'hD, 0, 0, 0, "after rst");
        for (int i = 0; i < 4; i++)
            step(0, 1, 1, 1, 4'h6, 4'hD, 1, 0, 0, "post rst a");
        step(0, 1, 0, 0, 4'h6, 4'hD, 0, 1, 1, "post rst b");
        step(0, 1, 0, 0, 4'h0, 4'h0, 0, 0, 1, "final idle");

        // MAX_HOLD=1: strict alternation
        step(1, 0, 1, 1, 4'h3, 4'hC, 0, 0, 0, "d1 rst");
        chk("d1 rst out", bus1.OUT, 4'h0);
        step(1, 1, 1, 1, 4'h3, 4'hC, 0, 0, 0, "d1 release");
        for (int i = 0; i < 4; i++) begin
            logic ga;
            ga = (i % 2 == 0);
            step(1, 1, 1, 1, 4'h3, 4'hC, ga, !ga, !ga, "alt");
        end
        step(1, 1, 0, 0, 4'h3, 4'hC, 1, 0, 0, "d1 drop");
        step(1, 1, 0, 0, 4'h0, 4'h0, 0, 0, 0, "d1 idle");

        @(negedge CLK);
        chk("q0 drained", W'(q0.size()), 4'h0);
        chk("q1 drained", W'(q1.size()), 4'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sel2_arbiter.md
# sel2_arbiter

Registered two-requester arbiter that shares a 2:1 selector between requester A and requester B. It owns the select line, issues one-hot grants, and registers the selected data word. It sits directly in front of the selector stage so that two producers can share one downstream path under round-robin scheduling with a bounded hold time.

## Interface

- WIDTH, 1, data width of A, B, OUT
- MAX_HOLD, 4, maximum consecutive transfers one requester gets while the other waits (legal range 1..255)

- CLK  input  1  rising-edge clock, only clock in the block
- RST_N  input  1  synchronous, active-low reset, sampled on the CLK rising edge
- REQ_A  input  1  requester A wants transfers (level, held while it has data)
- REQ_B  input  1  requester B wants transfers
- A  input  WIDTH  requester A data
- B  input  WIDTH  requester B data
- GNT_A  output  1  A granted (registered)
- GNT_B  output  1  B granted (registered)
- SEL  output  1  selector control: 0 = A, 1 = B (registered)
- OUT  output  WIDTH  registered selected data
- OUT_VALID  output  1  OUT holds a new transfer this cycle

## Operation

- States: IDLE, GRANT_A, GRANT_B. GNT_A=1 only in GRANT_A, GNT_B=1 only in GRANT_B. The grants are never both 1.
- LAST register: the last requester granted. Reset value is B, so A wins the first tie.
- CNT register: transfers completed in the current grant, 8 bits, saturates at MAX_HOLD. It resets to 0 on every grant entry.
- Transfer: a cycle in GRANT_A with REQ_A=1 (or GRANT_B with REQ_B=1). On the next edge: OUT <= (SEL ? B : A), OUT_VALID <= 1, CNT increments (saturating). Otherwise OUT holds and OUT_VALID <= 0.
- IDLE transitions:
  - Both requests high: grant the requester other than LAST.
  - One request high: grant that requester.
  - No request: stay in IDLE.
- GRANT_A transitions (GRANT_B is the mirror image):
  - REQ_A=0: no transfer. Go to GRANT_B if REQ_B=1, else IDLE.
  - REQ_A=1, REQ_B=1, and CNT+1 >= MAX_HOLD: transfer, then go to GRANT_B.
  - REQ_A=1, REQ_B=0: transfer, stay in GRANT_A. CNT saturates, so when B later requests, the switch happens right after the next A transfer.
  - Otherwise: transfer, stay in GRANT_A.
- On entering GRANT_x: SEL <= (x==B), LAST <= x, CNT <= 0. SEL holds its value in IDLE.
- MAX_HOLD=1 gives strict alternation while both requesters are active.

## Timing

- Reset: when RST_N=0 at an edge, the next state is:
  - state IDLE, GNT_A=0, GNT_B=0
  - SEL=0, OUT=0, OUT_VALID=0
  - CNT=0, LAST=B
- Reset takes priority over every other event, including a reset asserted in the middle of a grant. The first possible grant is at the edge after RST_N is sampled high.
- Grant latency: a REQ_x seen high in IDLE at edge n gives GNT_x=1 after edge n. The first transfer occurs in that cycle, and OUT/OUT_VALID reflect it after edge n+1.
- Handoff: the last transfer of A and the first grant of B occur on consecutive cycles, with no idle cycle. A handoff caused by REQ_x dropping costs exactly one non-transfer cycle.
- Data sampling: data is sampled in the transfer cycle. A requester must keep its data stable while it is granted and has REQ high.
- Combinational paths: all outputs are registered. There is no path from input to output.

## Test plan

- Reset: drive RST_N=0 for 2 cycles with REQ_A=REQ_B=1 and A=1, B=0, then release. Expect all outputs 0 during reset, and GNT_A=1 with SEL=0 on the first cycle after release.
- Single requester: REQ_A=1 for 5 cycles with A toggling. Expect GNT_A held for all 5 cycles, 5 consecutive OUT_VALID pulses delayed by one cycle, and OUT matching A.
- Contention, MAX_HOLD=4, both requesting continuously:
  - Expect the grant pattern AAAABBBBAAAA.
  - Expect SEL to change on the same edges as the grants.
  - Expect OUT_VALID to stay high continuously after the first transfer.
- Alternation, MAX_HOLD=1, both requesting: expect GNT_A/GNT_B to alternate every cycle, and OUT = A, B, A, B.
- Early release: A granted, drop REQ_A after 2 transfers while REQ_B=1.
  - Expect one cycle with OUT_VALID=0, then GNT_B.
  - After B drops, expect IDLE with SEL=1 held and both grants 0.
- Mid-grant reset: assert RST_N=0 for 1 cycle during GRANT_B with CNT=2. Expect all outputs cleared, then A granted first (LAST=B) when both requesters are active.
